// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and arithmetic helpers for the folded FIR filters
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Accumulator width that cannot overflow: pre-add (DW+1) times coefficient, HALF terms.
  function automatic int acc_width(input int dw, input int cw, input int half);
    return dw + 1 + cw + $clog2(half);
  endfunction

  // Round half up (when shift>0), arithmetic shift right, then clamp to a signed ow-bit range.
  // Operates on a 64-bit container so callers of any accumulator width up to 62 bits can share it.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift, input int ow);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sat_round.sv
// rtl/fir_sat_round.sv - combinational round-half-up and saturation of the accumulator
module fir_sat_round
  import fir_pkg::*;
#(
  parameter int ACCW  = 39,
  parameter int SHIFT = 23,
  parameter int OW    = 16
) (
  input  logic signed [ACCW-1:0] acc,
  output logic signed [OW-1:0]   q
);

  assign q = OW'(sat_round(64'(acc), SHIFT, OW));

endmodule

// File: rtl/fir_sym_folded.sv
// rtl/fir_sym_folded.sv - symmetric odd-length FIR with one time-multiplexed pre-add/MAC
module fir_sym_folded
  import fir_pkg::*;
#(
  parameter int NTAPS = 91,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 23,
  parameter int DECIM = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DW-1:0]                in_data,
  output logic                                out_valid,
  output logic signed [OW-1:0]                out_data,
  input  logic                                coef_we,
  input  logic [$clog2((NTAPS+1)/2)-1:0]      coef_addr,
  input  logic signed [CW-1:0]                coef_data,
  input  logic                                coef_commit
);

  localparam int HALF = (NTAPS + 1) / 2;
  localparam int AW   = $clog2(HALF);
  localparam int PW   = $clog2(NTAPS);
  localparam int PHW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ACCW = acc_width(DW, CW, HALF);

  localparam logic [PW-1:0]  PTR_LAST = PW'(NTAPS - 1);
  localparam logic [AW-1:0]  K_LAST   = AW'(HALF - 1);
  localparam logic [AW:0]    HALF_W   = (AW + 1)'(HALF);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(DECIM - 1);

  state_t state;
  state_t state_next;

  logic signed [DW-1:0]   line_mem    [NTAPS];
  logic signed [CW-1:0]   coef_shadow [HALF];
  logic signed [CW-1:0]   coef_active [HALF];
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          ia;
  logic [PW-1:0]          ib;
  logic [PW-1:0]          wptr_inc;
  logic [PW-1:0]          ia_dec;
  logic [PW-1:0]          ib_inc;
  logic [AW-1:0]          k;
  logic [PHW-1:0]         phase;
  logic                   pending;
  logic                   swap_now;
  logic                   accept;
  logic                   start;
  logic                   addr_ok;
  logic signed [ACCW-1:0] acc;
  logic signed [DW:0]     pre;
  logic signed [DW+CW:0]  prod;
  logic signed [OW-1:0]   sat_q;

  // The swap cycle blocks input so the bank copy never races a fresh accept.
  assign swap_now = (state == IDLE) && pending;
  assign in_ready = !rst && (state == IDLE) && !pending;
  assign accept   = in_valid && in_ready;
  assign start    = accept && (phase == '0);
  assign addr_ok  = coef_we && ({1'b0, coef_addr} < HALF_W);

  // ia walks from the newest sample backwards, ib from the oldest forwards; both wrap.
  assign wptr_inc = (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
  assign ia_dec   = (ia == '0) ? PTR_LAST : ia - PW'(1);
  assign ib_inc   = (ib == PTR_LAST) ? '0 : ib + PW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start a MAC pass only on accepted samples at decimation phase 0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (k == K_LAST) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Circular delay line and decimation phase, advanced on every accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) line_mem[i] <= '0;
      wptr  <= '0;
      phase <= '0;
    end else if (accept) begin
      line_mem[wptr] <= in_data;
      wptr           <= wptr_inc;
      phase          <= (phase == PH_LAST) ? '0 : phase + PHW'(1);
    end
  end

  // Shadow bank takes writes any time; active bank only loads from shadow on the swap cycle,
  // merging a same-cycle write so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        coef_shadow[i] <= '0;
        coef_active[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      for (int i = 0; i < HALF; i++) begin
        if (addr_ok && (coef_addr == AW'(i))) coef_shadow[i] <= coef_data;
        if (swap_now) begin
          coef_active[i] <= (addr_ok && (coef_addr == AW'(i))) ? coef_data : coef_shadow[i];
        end
      end
      if (coef_commit) begin
        pending <= 1'b1;
      end else if (swap_now) begin
        pending <= 1'b0;
      end
    end
  end

  // Pre-add of the symmetric pair (centre tap alone on the last term) and the product.
  always_comb begin
    pre = '0;
    if (k == K_LAST) begin
      pre = (DW + 1)'(line_mem[ia]);
    end else begin
      pre = (DW + 1)'(line_mem[ia]) + (DW + 1)'(line_mem[ib]);
    end
    prod = (DW + CW + 1)'(pre) * (DW + CW + 1)'(coef_active[k]);
  end

  // MAC sequencing: capture tap pointers at accept, accumulate one term per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      k   <= '0;
      ia  <= '0;
      ib  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            k   <= '0;
            ia  <= wptr;
            ib  <= wptr_inc;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          k   <= k + AW'(1);
          ia  <= ia_dec;
          ib  <= ib_inc;
        end
        default: ;
      endcase
    end
  end

  fir_sat_round #(
    .ACCW  (ACCW),
    .SHIFT (SHIFT),
    .OW    (OW)
  ) u_sat_round (
    .acc (acc),
    .q   (sat_q)
  );

  // Output register: one-cycle valid pulse, data held until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == OUT);
      if (state == OUT) out_data <= sat_q;
    end
  end

endmodule
